// File: rtl/key_entry_ctrl.sv
// Calculator key-entry controller: BCD operand entry, operator sequencing, ALU handshake.
// Latency: a key sampled with flag=1 is reflected on the registered outputs one cycle later.
// Backpressure: keys arriving while a calculation is in flight are dropped; alu_start is held until alu_done.
module key_entry_ctrl #(
  parameter int DIGITS   = 6,
  parameter bit CHAIN_EN = 1'b1
) (
  input  logic                  CLK_1K,
  input  logic                  RST,
  input  logic [3:0]            key_value,
  input  logic                  flag,
  input  logic [4*DIGITS-1:0]   num_result,
  input  logic                  alu_done,
  input  logic                  alu_err,
  output logic [4*DIGITS-1:0]   num_reg1,
  output logic [4*DIGITS-1:0]   num_reg2,
  output logic [3:0]            opcode,
  output logic                  alu_start,
  output logic [4*DIGITS-1:0]   num_out,
  output logic [3:0]            cnt1,
  output logic [3:0]            cnt2,
  output logic [2:0]            state_now,
  output logic                  err
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_CALC = 3'd3,
    S_RES  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_reg1;
  logic [W-1:0]   r_reg2;
  logic [3:0]     r_cnt1;
  logic [3:0]     r_cnt2;
  logic [3:0]     r_opcode;
  logic [3:0]     r_pend_op;
  logic [3:0]     r_follow_op;
  logic           r_chained;
  logic           r_alu_start;
  logic           r_err;

  logic           w_is_digit;
  logic           w_is_op;
  logic           w_is_eq;
  logic           w_is_clr;
  logic           w_full_clr;
  logic [W+3:0]   w_app1;
  logic [W+3:0]   w_app2;
  logic [W+3:0]   w_new;

  // Append one BCD digit to an operand; returns {count, value}.
  // A leading zero is swallowed and a full operand ignores further digits.
  function automatic logic [W+3:0] append_digit(input logic [W-1:0] v,
                                                input logic [3:0]   c,
                                                input logic [3:0]   d);
    if (c == 4'(DIGITS))
      return {c, v};
    else if (c == 4'd0 && d == 4'd0)
      return {4'd0, {W{1'b0}}};
    else if (c == 4'd0)
      return {4'd1, {(W-4){1'b0}}, d};
    else
      return {c + 4'd1, v[W-5:0], d};
  endfunction

  // Key classification and digit-append candidates for both operands.
  always_comb begin
    w_is_digit = (key_value <= 4'd9);
    w_is_op    = (key_value >= 4'hA) && (key_value <= 4'hD);
    w_is_eq    = (key_value == 4'hE);
    w_is_clr   = (key_value == 4'hF);
    w_full_clr = flag && w_is_clr &&
                 (r_state == S_A || r_state == S_OP || r_state == S_RES || r_state == S_ERR);
    w_app1     = append_digit(r_reg1, r_cnt1, key_value);
    w_app2     = append_digit(r_reg2, r_cnt2, key_value);
    w_new      = append_digit({W{1'b0}}, 4'd0, key_value);
  end

  // Main entry FSM with registered outputs; F in idle states is a full clear.
  always_ff @(posedge CLK_1K or negedge RST) begin
    if (!RST) begin
      r_state     <= S_A;
      r_reg1      <= '0;
      r_reg2      <= '0;
      r_cnt1      <= '0;
      r_cnt2      <= '0;
      r_opcode    <= '0;
      r_pend_op   <= '0;
      r_follow_op <= '0;
      r_chained   <= 1'b0;
      r_alu_start <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_full_clr) begin
      r_state     <= S_A;
      r_reg1      <= '0;
      r_reg2      <= '0;
      r_cnt1      <= '0;
      r_cnt2      <= '0;
      r_opcode    <= '0;
      r_pend_op   <= '0;
      r_follow_op <= '0;
      r_chained   <= 1'b0;
      r_alu_start <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_A: begin
          if (flag) begin
            if (w_is_digit) begin
              {r_cnt1, r_reg1} <= w_app1;
            end else if (w_is_op) begin
              r_pend_op <= key_value;
              r_state   <= S_OP;
            end
          end
        end
        S_OP: begin
          if (flag) begin
            if (w_is_op) begin
              r_pend_op <= key_value;
            end else if (w_is_digit) begin
              {r_cnt2, r_reg2} <= w_new;
              r_state          <= S_B;
            end
          end
        end
        S_B: begin
          if (flag) begin
            if (w_is_digit) begin
              {r_cnt2, r_reg2} <= w_app2;
            end else if (w_is_eq || (CHAIN_EN && w_is_op)) begin
              // An operator here both launches the calculation and queues itself as the next one.
              r_opcode    <= r_pend_op;
              r_alu_start <= 1'b1;
              r_chained   <= w_is_op;
              if (w_is_op)
                r_follow_op <= key_value;
              r_state     <= S_CALC;
            end else if (w_is_clr) begin
              r_reg2  <= '0;
              r_cnt2  <= '0;
              r_state <= S_OP;
            end
          end
        end
        S_CALC: begin
          if (alu_done) begin
            r_alu_start <= 1'b0;
            if (alu_err) begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end else begin
              // Result is marked full so further digits cannot extend it.
              r_reg1 <= num_result;
              r_reg2 <= '0;
              r_cnt1 <= 4'(DIGITS);
              r_cnt2 <= '0;
              if (r_chained) begin
                r_pend_op <= r_follow_op;
                r_state   <= S_OP;
              end else begin
                r_state   <= S_RES;
              end
            end
          end
        end
        S_RES: begin
          if (flag) begin
            if (w_is_digit) begin
              {r_cnt1, r_reg1} <= w_new;
              r_cnt2           <= '0;
              r_state          <= S_A;
            end else if (w_is_op) begin
              r_pend_op <= key_value;
              r_state   <= S_OP;
            end
          end
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: r_state <= S_A;
      endcase
    end
  end

  // Display shows operand B while it is being entered and blanks on error.
  always_comb begin
    if (r_state == S_B)
      num_out = r_reg2;
    else if (r_state == S_ERR)
      num_out = '0;
    else
      num_out = r_reg1;
  end

  assign num_reg1  = r_reg1;
  assign num_reg2  = r_reg2;
  assign opcode    = r_opcode;
  assign alu_start = r_alu_start;
  assign cnt1      = r_cnt1;
  assign cnt2      = r_cnt2;
  assign state_now = r_state;
  assign err       = r_err;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Testbench for key_entry_ctrl: directed scenarios plus random keys and ALU responses,
// checked against a behavioural calculator model through an expectation queue.
module tb_key_entry_ctrl;
  localparam int DIGITS = 6;
  localparam int W      = 4 * DIGITS;

  logic           CLK_1K = 1'b0;
  logic           RST    = 1'b0;
  logic [3:0]     key_value = '0;
  logic           flag = 1'b0;
  logic [W-1:0]   num_result = '0;
  logic           alu_done = 1'b0;
  logic           alu_err = 1'b0;
  logic [W-1:0]   num_reg1, num_reg2, num_out;
  logic [3:0]     opcode, cnt1, cnt2;
  logic           alu_start, err;
  logic [2:0]     state_now;

  key_entry_ctrl #(.DIGITS(DIGITS), .CHAIN_EN(1'b1)) dut (
    .CLK_1K(CLK_1K), .RST(RST), .key_value(key_value), .flag(flag),
    .num_result(num_result), .alu_done(alu_done), .alu_err(alu_err),
    .num_reg1(num_reg1), .num_reg2(num_reg2), .opcode(opcode), .alu_start(alu_start),
    .num_out(num_out), .cnt1(cnt1), .cnt2(cnt2), .state_now(state_now), .err(err)
  );

  always #5 CLK_1K = ~CLK_1K;

  typedef struct {
    logic [2:0]   st;
    logic [W-1:0] r1, r2, out;
    logic [3:0]   opc, c1, c2;
    logic         start, err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Behavioural calculator model: modes and operands as plain numbers.
  int           m_st;
  logic [W-1:0] m_a, m_b;
  int           m_ac, m_bc;
  logic [3:0]   m_pend, m_follow, m_opc;
  bit           m_chain, m_start, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_st = 0; m_a = '0; m_b = '0; m_ac = 0; m_bc = 0;
    m_pend = '0; m_follow = '0; m_opc = '0; m_chain = 0; m_start = 0; m_err = 0;
  endtask

  // Typing a digit multiplies the shown number by ten-in-BCD (x16) and adds it.
  task automatic type_digit(inout logic [W-1:0] v, inout int c, input int d);
    if (c == DIGITS) return;
    if (c == 0 && d == 0) begin v = '0; return; end
    v = v * 16 + W'(d);
    c++;
  endtask

  task automatic model_step(input bit vld, input int k, input bit done, input bit aerr,
                            input logic [W-1:0] res);
    bit dig, op;
    dig = (k <= 9);
    op  = (k >= 10 && k <= 13);
    if (m_st == 3) begin
      if (done) begin
        m_start = 0;
        if (aerr) begin m_err = 1; m_st = 5; end
        else begin
          m_a = res; m_ac = DIGITS; m_b = '0; m_bc = 0;
          if (m_chain) begin m_pend = m_follow; m_st = 1; end
          else m_st = 4;
        end
      end
    end else if (vld) begin
      if (k == 15 && m_st != 2) model_clear();
      else case (m_st)
        0: if (dig) type_digit(m_a, m_ac, k);
           else if (op) begin m_pend = 4'(k); m_st = 1; end
        1: if (op) m_pend = 4'(k);
           else if (dig) begin m_b = '0; m_bc = 0; type_digit(m_b, m_bc, k); m_st = 2; end
        2: if (dig) type_digit(m_b, m_bc, k);
           else if (k == 14 || op) begin
             m_opc = m_pend; m_start = 1; m_chain = op;
             if (op) m_follow = 4'(k);
             m_st = 3;
           end else if (k == 15) begin m_b = '0; m_bc = 0; m_st = 1; end
        4: if (dig) begin m_a = '0; m_ac = 0; type_digit(m_a, m_ac, k); m_bc = 0; m_st = 0; end
           else if (op) begin m_pend = 4'(k); m_st = 1; end
        default: ;
      endcase
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.st = 3'(m_st); e.r1 = m_a; e.r2 = m_b; e.opc = m_opc;
    e.c1 = 4'(m_ac); e.c2 = 4'(m_bc); e.start = m_start; e.err = m_err;
    e.out = (m_st == 2) ? m_b : (m_st == 5) ? '0 : m_a;
    sb.push_back(e);
  endtask

  // One clock of stimulus: drive inputs, advance the model, queue the expected outcome.
  task automatic cyc(input bit vld, input logic [3:0] k, input bit done, input bit aerr,
                     input logic [W-1:0] res);
    @(negedge CLK_1K);
    flag = vld; key_value = k; alu_done = done; alu_err = aerr; num_result = res;
    model_step(vld, int'(k), done, aerr, res);
    push_exp();
  endtask

  task automatic press(input logic [3:0] k);
    cyc(1'b1, k, 1'b0, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'b0, '0);
  endtask

  task automatic alu_ret(input int lat, input logic [W-1:0] res, input bit aerr);
    idle(lat - 1);
    cyc(1'b0, 4'h0, 1'b1, aerr, res);
  endtask

  task automatic settle();
    @(posedge CLK_1K);
    #2;
  endtask

  // Monitor: every clock after an expectation is queued, compare all outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK_1K);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("state_now", 32'(state_now), 32'(e.st));
        chk("num_reg1", 32'(num_reg1), 32'(e.r1));
        chk("num_reg2", 32'(num_reg2), 32'(e.r2));
        chk("num_out", 32'(num_out), 32'(e.out));
        chk("opcode", 32'(opcode), 32'(e.opc));
        chk("cnt1", 32'(cnt1), 32'(e.c1));
        chk("cnt2", 32'(cnt2), 32'(e.c2));
        chk("alu_start", 32'(alu_start), 32'(e.start));
        chk("err", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    RST = 1'b0;
    #12;
    chk("reset_state", 32'(state_now), 0);
    chk("reset_reg1", 32'(num_reg1), 0);
    chk("reset_reg2", 32'(num_reg2), 0);
    chk("reset_opcode", 32'(opcode), 0);
    chk("reset_cnt1", 32'(cnt1), 0);
    chk("reset_cnt2", 32'(cnt2), 0);
    chk("reset_start", 32'(alu_start), 0);
    chk("reset_err", 32'(err), 0);
    @(negedge CLK_1K);
    RST = 1'b1;

    // 123 A 45 = with a three-cycle ALU
    press(4'h1); press(4'h2); press(4'h3); press(4'hA); press(4'h4); press(4'h5); press(4'hE);
    alu_ret(3, 24'h000168, 1'b0);
    settle();
    chk("add_reg1", 32'(num_reg1), 32'h168);
    chk("add_state", 32'(state_now), 4);
    chk("add_cnt1", 32'(cnt1), 6);
    chk("add_opcode", 32'(opcode), 32'hA);

    // Leading zeros and overflow digits
    press(4'hF);
    press(4'h0); press(4'h0);
    for (int d = 1; d <= 7; d++) press(4'(d));
    settle();
    chk("lead0_reg1", 32'(num_reg1), 32'h123456);
    chk("lead0_cnt1", 32'(cnt1), 6);

    // Chained operation, then a key dropped during the second calculation
    press(4'hF);
    press(4'h2); press(4'hA); press(4'h3); press(4'hB);
    alu_ret(2, 24'h5, 1'b0);
    settle();
    chk("chain_state", 32'(state_now), 1);
    chk("chain_reg1", 32'(num_reg1), 32'h5);
    press(4'h1); press(4'hE);
    settle();
    chk("chain_opcode", 32'(opcode), 32'hB);
    chk("chain_start", 32'(alu_start), 1);
    press(4'h7);
    alu_ret(2, 24'h4, 1'b0);

    // Divide by zero then recovery
    press(4'h8); press(4'hD); press(4'h0); press(4'hE);
    alu_ret(1, 24'h0, 1'b1);
    settle();
    chk("err_state", 32'(state_now), 5);
    chk("err_flag", 32'(err), 1);
    chk("err_out", 32'(num_out), 0);
    press(4'h3); press(4'hF);
    settle();
    chk("errclr_state", 32'(state_now), 0);
    chk("errclr_reg1", 32'(num_reg1), 0);

    // Clear-entry of operand B
    press(4'h9); press(4'hC); press(4'h4); press(4'h4); press(4'hF);
    settle();
    chk("ce_reg2", 32'(num_reg2), 0);
    chk("ce_state", 32'(state_now), 1);
    chk("ce_reg1", 32'(num_reg1), 32'h9);

    // Reset during an in-flight calculation
    press(4'h1); press(4'hE); idle(1);
    @(negedge CLK_1K);
    RST = 1'b0;
    #1;
    chk("midcalc_rst_start", 32'(alu_start), 0);
    chk("midcalc_rst_state", 32'(state_now), 0);
    model_clear();
    repeat (2) @(negedge CLK_1K);
    RST = 1'b1;

    // Random keys, ALU latencies, errors and stray alu_done strobes
    for (int i = 0; i < 800; i++) begin
      if (m_st == 3) begin
        if ($urandom_range(0, 2) == 0)
          cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1,
              ($urandom_range(0, 4) == 0), W'($urandom));
        else
          cyc(1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 1'b0, 1'b0, '0);
      end else begin
        logic [3:0] k;
        k = 4'($urandom_range(0, 15));
        if (k == 4'hF && $urandom_range(0, 2) != 0) k = 4'hE;
        cyc(($urandom_range(0, 9) < 6), k, ($urandom_range(0, 9) == 0), 1'($urandom), W'($urandom));
      end
    end
    idle(2);
    settle();
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_entry_ctrl.md
KEY_ENTRY_CTRL -- requirements
Module: key_entry_ctrl

Interface
REQ-001 Parameter DIGITS, default 6, legal 2..8: BCD digits per operand. Operand width W = 4*DIGITS.
REQ-002 Parameter CHAIN_EN, default 1: an operator key pressed after operand B starts a calculation and chains.
REQ-003 CLK_1K  input  1  single system clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 key_value  input  4  key code: 0-9 digit, A-D operator, E equals, F clear.
REQ-006 flag  input  1  one-cycle key-valid strobe.
REQ-007 num_result  input  W  ALU result, valid when alu_done=1.
REQ-008 alu_done  input  1  ALU completion strobe.
REQ-009 alu_err  input  1  ALU error (divide by zero), qualified by alu_done.
REQ-010 num_reg1  output  W  operand A / last result.
REQ-011 num_reg2  output  W  operand B.
REQ-012 opcode  output  4  operator issued to the ALU.
REQ-013 alu_start  output  1  calculation request level.
REQ-014 num_out  output  W  display value.
REQ-015 cnt1, cnt2  output  4 each  digit counts of A and B.
REQ-016 state_now  output  3  current state.
REQ-017 err  output  1  error indicator.

Function
REQ-018 States: S_A=0 (enter A), S_OP=1 (operator pending), S_B=2 (enter B), S_CALC=3, S_RES=4, S_ERR=5. Codes 6-7 recover to S_A on the next edge.
REQ-019 A key is processed only when flag=1. Its effect is visible on outputs one cycle after flag is sampled. Keys arriving in S_CALC are dropped.
REQ-020 Digit entry on the active operand: shift left 4 bits, insert the digit, increment the count.
- A digit 0 when count=0 leaves the register at 0 and does not increment the count.
- When count=DIGITS, further digits are ignored.
REQ-021 S_A:
- digit: appends to num_reg1.
- A-D: latches the internal pending operator, goes to S_OP.
- E: ignored.
REQ-022 S_OP:
- A-D: replaces the pending operator.
- digit: loads num_reg2 with that digit, sets cnt2 per REQ-020, goes to S_B.
- E: ignored.
REQ-023 S_B:
- digit: appends to num_reg2.
- E: opcode <= pending operator, alu_start <= 1, go to S_CALC.
- A-D with CHAIN_EN=1: same as E, and the new operator is stored as the follow-on operator.
- A-D with CHAIN_EN=0: ignored.
REQ-024 S_CALC: alu_start is held at 1 until alu_done=1 is sampled, then drops to 0 on the next edge. alu_done outside S_CALC is ignored.
REQ-025 On alu_done with alu_err=0:
- num_reg1 <= num_result, num_reg2 <= 0, cnt2 <= 0, cnt1 <= DIGITS (the result is not appendable).
- Next state is S_OP with the follow-on operator pending if chained, otherwise S_RES.
REQ-026 On alu_done with alu_err=1: go to S_ERR, err <= 1; num_reg1 and num_reg2 are unchanged.
REQ-027 S_RES:
- digit: num_reg1 <= digit, cnt1 per REQ-020, cnt2 <= 0, go to S_A.
- A-D: latches the operator, goes to S_OP with the result as A.
- E: ignored.
REQ-028 Key F:
- in S_B: clears num_reg2 and cnt2, goes to S_OP (clear entry).
- in S_A, S_OP, S_RES and S_ERR: full clear to reset values.
- in S_CALC: dropped.
REQ-029 S_ERR: all keys except F are ignored.
REQ-030 num_out is combinational:
- num_reg2 in S_B.
- 0 in S_ERR.
- num_reg1 otherwise.
REQ-031 opcode changes only on the edge that raises alu_start.

Reset
REQ-032 While RST=0, regardless of state or an in-flight calculation:
- state_now=S_A.
- num_reg1, num_reg2, opcode, cnt1, cnt2 = 0.
- alu_start=0, err=0.
- pending and follow-on operators = 0.
REQ-033 The first key after RST deasserts is processed normally.

Verification
REQ-034 DIGITS=6. Keys 1,2,3,A,4,5,E; ALU returns 0x000168 after 3 cycles -> alu_start high for exactly those 3 cycles, opcode=0xA, num_reg1=0x000168, state S_RES, cnt1=6.
REQ-035 Keys 0,0,1,2,3,4,5,6,7 -> num_reg1=0x123456, cnt1=6; leading zeros are not counted.
REQ-036 CHAIN_EN=1: keys 2,A,3,B; ALU result 0x5 -> state S_OP, num_reg1=0x5; then 1,E -> opcode=0xB, alu_start=1.
REQ-037 Keys 8,D,0,E; alu_done with alu_err=1 -> S_ERR, err=1, num_out=0; digit ignored; F -> S_A with all outputs 0.
REQ-038 Keys 9,C,4,4,F -> num_reg2=0, cnt2=0, S_OP, num_reg1=0x9.
REQ-039 RST low while in S_CALC with alu_start=1 -> alu_start=0 immediately and S_A.
REQ-040 flag during S_CALC -> the key is dropped.
